// File: rtl/m16_pkg.sv
// Shared constants, FSM state type and operand helper for the MAC stage
// that feeds the saturation stage.
package m16_pkg;

  localparam int DATA_W    = 8;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int MUL_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  // Two's-complement magnitude; -128 maps to 0x80, which reads correctly as unsigned 128.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/shift_add_mul8.sv
// Iterative unsigned 8x8 shift-add multiplier: load captures the operands,
// then one partial product is added per clock; done rises after MUL_STEPS steps.
module shift_add_mul8
  import m16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic [PROD_W-1:0] prod,
  output logic              done
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  logic [PROD_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [CNT_W-1:0]  step;

  assign done = (step == CNT_W'(MUL_STEPS));

  // Out of reset the step counter sits at MUL_STEPS so no stray steps run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step     <= CNT_W'(MUL_STEPS);
    end else if (load) begin
      prod     <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, mcand};
      mplier_q <= mplier;
      step     <= '0;
    end else if (!done) begin
      if (mplier_q[0]) prod <= prod + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      step     <= step + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Iterative 8x8 multiply-accumulate with a wide signed accumulator; presents the
// low byte plus range flags to the downstream saturation stage.
module mac_accumulator
  import m16_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              sub,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] result,
  output logic              sat_enable,
  output logic              sat_sign,
  output logic              sat_last
);

  // Handshake: start/clear are honoured only while IDLE (busy=0) and are otherwise
  // dropped; busy stays high from the accepting edge until the accumulate edge, and
  // valid pulses for exactly one cycle when result/sat_* take their new values.

  localparam int CNT_W = $clog2(MUL_STEPS);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               neg;
  logic               mode;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   prod_ext;
  logic [PROD_W-1:0]  prod;
  logic               mul_done;
  logic               mul_load;
  logic               in_range;

  assign mul_load = (state == IDLE) && start;

  shift_add_mul8 u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mul_load),
    .mcand  (magnitude(op_a, signed_mode)),
    .mplier (magnitude(op_b, signed_mode)),
    .prod   (prod),
    .done   (mul_done)
  );

  assign prod_ext = ACC_W'(prod);
  assign acc_next = neg ? (acc - prod_ext) : (acc + prod_ext);

  // Signed range: bits above bit 6 are pure sign extension. Unsigned: nothing above bit 7.
  always_comb begin
    in_range = 1'b0;
    if (mode) begin
      in_range = (&acc_next[ACC_W-1:DATA_W-1]) || !(|acc_next[ACC_W-1:DATA_W-1]);
    end else begin
      in_range = !(|acc_next[ACC_W-1:DATA_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      neg        <= 1'b0;
      mode       <= 1'b0;
      acc        <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      result     <= '0;
      sat_enable <= 1'b0;
      sat_sign   <= 1'b0;
      sat_last   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          // Clear lands first, so a combined clear+start accumulates onto zero.
          if (clear) acc <= '0;
          if (start) begin
            neg   <= (signed_mode & (op_a[DATA_W-1] ^ op_b[DATA_W-1])) ^ sub;
            mode  <= signed_mode;
            busy  <= 1'b1;
            count <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(MUL_STEPS - 1)) state <= ACC;
        end
        ACC: begin
          if (mul_done) begin
            acc        <= acc_next;
            result     <= acc_next[DATA_W-1:0];
            sat_enable <= !in_range;
            sat_sign   <= acc_next[ACC_W-1];
            sat_last   <= mode;
            valid      <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed vector table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference model.
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       sub = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       busy, valid, sat_enable, sat_sign, sat_last;
  logic [7:0] result;

  int tests = 0;
  int fails = 0;
  int acc_m = 0;
  logic [10:0] exp_q[$];
  logic [10:0] last_exp = '0;

  typedef struct {
    logic       clr;
    logic       sb;
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       en;
    logic       sg;
    logic       lst;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  mac_accumulator #(.ACC_W(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear       (clear),
    .sub         (sub),
    .signed_mode (signed_mode),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .valid       (valid),
    .result      (result),
    .sat_enable  (sat_enable),
    .sat_sign    (sat_sign),
    .sat_last    (sat_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: real integer arithmetic, wrapped to the 20-bit accumulator.
  task automatic model_op(input logic clr, input logic sb, input logic sm,
                          input logic [7:0] a, input logic [7:0] b);
    int av, bv, p;
    logic [19:0] t;
    logic en, sg;
    if (sm) begin
      av = int'(signed'(a));
      bv = int'(signed'(b));
    end else begin
      av = int'(a);
      bv = int'(b);
    end
    p = av * bv;
    if (clr) acc_m = 0;
    acc_m = sb ? (acc_m - p) : (acc_m + p);
    t = acc_m[19:0];
    acc_m = int'(signed'(t));
    en = sm ? (acc_m < -128 || acc_m > 127) : (acc_m < 0 || acc_m > 255);
    sg = (acc_m < 0);
    exp_q.push_back({acc_m[7:0], en, sg, sm});
  endtask

  task automatic compare_outputs(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_unexpected_valid: got valid=1, expected no pending op", tag);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check({tag, "_result"}, 32'(result), 32'(e[10:3]));
      check({tag, "_sat_enable"}, 32'(sat_enable), 32'(e[2]));
      check({tag, "_sat_sign"}, 32'(sat_sign), 32'(e[1]));
      check({tag, "_sat_last"}, 32'(sat_last), 32'(e[0]));
      check({tag, "_busy_low"}, 32'(busy), 32'(0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_op(input logic clr, input logic sb, input logic sm,
                       input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    clear = clr; sub = sb; signed_mode = sm; op_a = a; op_b = b; start = 1'b1;
    model_op(clr, sb, sm, a, b);
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    // Operands must have been captured at the start edge only.
    op_a = 8'($urandom); op_b = 8'($urandom);
    sub = 1'($urandom); signed_mode = 1'($urandom);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'(9));
    if (lat != 0) compare_outputs("op");
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, nv, cyc, last_cyc;
    logic rc, rs, rm;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h0A, 8'h14, 8'hC8, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'hF4, 8'h0B, 8'h7C, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h80, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h0A, 8'h14, 8'hC8, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hC8, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_sat_enable", 32'(sat_enable), 32'(0));
    check("rst_sat_sign", 32'(sat_sign), 32'(0));
    check("rst_sat_last", 32'(sat_last), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].clr, vecs[i].sb, vecs[i].sm, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].r));
      check($sformatf("vec%0d_sat_enable", i), 32'(sat_enable), 32'(vecs[i].en));
      check($sformatf("vec%0d_sat_sign", i), 32'(sat_sign), 32'(vecs[i].sg));
      check($sformatf("vec%0d_sat_last", i), 32'(sat_last), 32'(vecs[i].lst));
    end

    // start and clear pulsed mid-MUL are ignored
    @(negedge clk);
    start = 1'b1; clear = 1'b0; sub = 1'b0; signed_mode = 1'b0; op_a = 8'd3; op_b = 8'd4;
    model_op(1'b0, 1'b0, 1'b0, 8'd3, 8'd4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midop_busy", 32'(busy), 32'(1));
    @(negedge clk);
    start = 1'b1; clear = 1'b1; op_a = 8'h55; op_b = 8'h66;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    nv = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        nv++;
        compare_outputs("midop");
      end
    end
    check("midop_valid_count", 32'(nv), 32'(1));

    // Back-to-back starts: one valid every 10 cycles
    @(negedge clk);
    start = 1'b1; clear = 1'b0; sub = 1'b0; signed_mode = 1'b0; op_a = 8'd2; op_b = 8'd3;
    for (int k = 0; k < 3; k++) model_op(1'b0, 1'b0, 1'b0, 8'd2, 8'd3);
    nv = 0; cyc = 0; last_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (valid) begin
        if (nv > 0) check("b2b_gap", 32'(cyc - last_cyc), 32'(10));
        last_cyc = cyc;
        nv++;
        compare_outputs("b2b");
        if (nv == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_valid_count", 32'(nv), 32'(3));

    // clear alone: accumulator zeroed, outputs held, no valid
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    acc_m = 0;
    nv = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check("clear_no_valid", 32'(nv), 32'(0));
    check("clear_hold_result", 32'(result), 32'(last_exp[10:3]));
    check("clear_hold_flags", 32'({sat_enable, sat_sign, sat_last}), 32'(last_exp[2:0]));
    do_op(1'b0, 1'b0, 1'b1, 8'd1, 8'd1, lat);
    check("after_clear_result", 32'(result), 32'(8'h01));
    check("after_clear_sat_last", 32'(sat_last), 32'(1));

    // Reset during MUL aborts the op
    @(negedge clk);
    start = 1'b1; clear = 1'b0; sub = 1'b0; signed_mode = 1'b1; op_a = 8'd9; op_b = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_valid", 32'(valid), 32'(0));
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_flags", 32'({sat_enable, sat_sign, sat_last}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_m = 0;
    do_op(1'b0, 1'b0, 1'b0, 8'd3, 8'd5, lat);
    check("after_rst_result", 32'(result), 32'(8'h0F));

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      rc = ($urandom_range(0, 3) == 0);
      rs = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      do_op(rc, rs, rm, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
